ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter C_IMG_COLS, default 640, pixels per line.
REQ-002 SHALL have parameter C_IMG_ROWS, default 480, lines per frame.
REQ-003 SHALL have parameter C_IMG_PXLS, default C_IMG_COLS*C_IMG_ROWS, pixels per frame.
REQ-004 SHALL have parameter C_NB_IMG_PXLS, default 19, address width.
REQ-005 SHALL have port clk, input, 1, camera pixel clock (PCLK); the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port cap_en, input, 1, capture enable, sampled only at frame start.
REQ-008 SHALL have port vsync, input, 1, camera VSYNC; high = vertical blanking.
REQ-009 SHALL have port href, input, 1, camera HREF; high = valid byte on d.
REQ-010 SHALL have port d, input, 8, camera data byte, RGB565, high byte first.
REQ-011 SHALL have port we, output, 1, frame-buffer write strobe.
REQ-012 SHALL have port addr, output, C_NB_IMG_PXLS, frame-buffer write address.
REQ-013 SHALL have port dout, output, 12, RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at end of a captured frame.
REQ-015 SHALL have port overflow, output, 1, sticky flag: frame had more than C_IMG_PXLS pixels.

Function
REQ-016 SHALL implement states IDLE, WAIT_SYNC, ACTIVE; reset state IDLE.
REQ-017 IDLE: go to WAIT_SYNC when vsync=1 and cap_en=1; otherwise stay.
REQ-018 WAIT_SYNC: go to ACTIVE on the first cycle with vsync=0; clear pixel counter, byte phase, overflow on that transition.
REQ-019 ACTIVE: on vsync=1 pulse frame_done for exactly one cycle (the next cycle); then go to WAIT_SYNC if cap_en=1, else IDLE.
REQ-020 cap_en going low inside ACTIVE SHALL NOT abort the frame; the frame completes normally.
REQ-021 Byte phase SHALL toggle on each ACTIVE cycle with href=1 and SHALL be forced to 0 on any cycle with href=0.
REQ-022 Phase 0 byte SHALL be latched as high byte {R[4:0],G[5:3]}; phase 1 byte completes the pixel {G[2:0],B[4:0]}.
REQ-023 On the phase-1 edge: we<=1, dout<={R[4:1],G[5:2],B[4:1]}, addr<=pixel counter, counter<=counter+1; outputs valid in the following cycle (latency 1 cycle after the second byte).
REQ-024 we SHALL be high for exactly one cycle per pixel and low at all other times, including IDLE and WAIT_SYNC.
REQ-025 Pixel counter SHALL be C_NB_IMG_PXLS wide and SHALL not advance past C_IMG_PXLS.
REQ-026 A completed pixel with counter=C_IMG_PXLS SHALL produce no write and SHALL set overflow; overflow holds until cleared per REQ-018 or reset.
REQ-027 href falling while phase=1 is pending (odd byte count) SHALL discard the half pixel; no write.
REQ-028 A short frame (vsync rises with counter<C_IMG_PXLS) SHALL still pulse frame_done; no flag.
REQ-029 addr and dout SHALL hold their last values when we=0.
REQ-030 href=1 outside ACTIVE SHALL be ignored.

Reset
REQ-031 With rst_n=0 at a rising edge: state=IDLE, we=0, addr=0, dout=0, frame_done=0, overflow=0, counter=0, phase=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without frame_done; capture restarts only at the next vsync high then low.

Verification
REQ-033 Reset, cap_en=1, vsync 1->0, href=1 with bytes 0xF8,0x1F -> one cycle later we=1, addr=0, dout=0xF0F.
REQ-034 Full 640x480 frame of bytes 0x07,0xE0 then vsync=1 -> 307200 writes, last addr=307199, dout=0x0F0 each, frame_done one pulse, overflow=0.
REQ-035 Frame with 307201 pixels -> 307200 writes, no write for extra pixel, overflow=1 until next frame start.
REQ-036 Line with 3 bytes (href drops after 3rd) -> exactly one write; next line starts at phase 0 and next addr.
REQ-037 cap_en=0 at reset, vsync toggling, href active -> we never asserted; cap_en=1 then -> capture starts at next vsync falling edge.
REQ-038 rst_n=0 at pixel 1000 -> all outputs reset next edge, no frame_done; next frame writes from addr=0.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 camera capture: assembles RGB565 byte pairs from the sensor bus into
// RGB444 pixels and writes them into a frame buffer, one address per pixel.
// Everything runs in the camera PCLK domain.
//
// Bus behaviour: the sensor gives no back-pressure. A byte is valid on d on
// every cycle with href=1 while a frame is active. The frame-buffer write is a
// one-cycle strobe (we) with addr/dout valid in the same cycle. addr/dout
// hold their last values while we=0.
module ov7670_capture #(
  parameter int C_IMG_COLS    = 640,
  parameter int C_IMG_ROWS    = 480,
  parameter int C_IMG_PXLS    = C_IMG_COLS * C_IMG_ROWS,
  parameter int C_NB_IMG_PXLS = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               d,
  output logic                     we,
  output logic [C_NB_IMG_PXLS-1:0] addr,
  output logic [11:0]              dout,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_ACTIVE    = 2'd2
  } state_t;

  // Pixel count limit and increment at the counter's own width.
  localparam logic [C_NB_IMG_PXLS-1:0] L_MAX = C_NB_IMG_PXLS'(C_IMG_PXLS);
  localparam logic [C_NB_IMG_PXLS-1:0] L_ONE = C_NB_IMG_PXLS'(1);

  state_t                     r_state;
  logic                       r_phase;
  logic [6:0]                 r_hi;      // {R[4:1], G[5:3]} of the pending pixel
  logic [C_NB_IMG_PXLS-1:0]   r_cnt;
  logic                       r_we;
  logic [C_NB_IMG_PXLS-1:0]   r_addr;
  logic [11:0]                r_dout;
  logic                       r_frame_done;
  logic                       r_ovf;

  // RGB444 pixel from the latched high byte and the current low byte:
  // R[4:1] = hi[7:4], G[5:2] = {hi[2:0], lo[7]}, B[4:1] = lo[4:1].
  logic [11:0]                w_pixel;
  logic                       w_room;

  assign w_pixel = {r_hi[6:3], r_hi[2:0], d[7], d[4:1]};
  assign w_room  = (r_cnt < L_MAX);

  // Frame state machine, byte pairing and frame-buffer write generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_phase <= 1'b0;
          if (vsync && cap_en) begin
            r_state <= S_WAIT_SYNC;
          end
        end

        S_WAIT_SYNC: begin
          r_phase <= 1'b0;
          // End of vertical blanking: a new frame starts from a clean slate.
          if (!vsync) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end

        S_ACTIVE: begin
          if (vsync) begin
            // Frame over; cap_en is only consulted here, so dropping it
            // mid-frame lets the current frame finish.
            r_frame_done <= 1'b1;
            r_phase      <= 1'b0;
            r_state      <= cap_en ? S_WAIT_SYNC : S_IDLE;
          end else if (href) begin
            if (!r_phase) begin
              r_hi    <= {d[7:4], d[2:0]};
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_room) begin
                r_we   <= 1'b1;
                r_addr <= r_cnt;
                r_dout <= w_pixel;
                r_cnt  <= r_cnt + L_ONE;
              end else begin
                // Frame longer than the buffer: drop the pixel, flag it.
                r_ovf <= 1'b1;
              end
            end
          end else begin
            // href low discards any half-received pixel.
            r_phase <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

  assign we         = r_we;
  assign addr       = r_addr;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign overflow   = r_ovf;
  assign o_state    = r_state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture using a reduced 4x3 frame.
module tb_ov7670_capture;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int PXLS = COLS * ROWS;
  localparam int NB   = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_en;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic          we;
  logic [NB-1:0] addr;
  logic [11:0]   dout;
  logic          frame_done;
  logic          overflow;
  logic [1:0]    o_state;

  always #5 clk = ~clk;

  ov7670_capture #(
    .C_IMG_COLS   (COLS),
    .C_IMG_ROWS   (ROWS),
    .C_IMG_PXLS   (PXLS),
    .C_NB_IMG_PXLS(NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .we        (we),
    .addr      (addr),
    .dout      (dout),
    .frame_done(frame_done),
    .overflow  (overflow),
    .o_state   (o_state)
  );

  // ---------------- stimulus table (hand-computed RGB444) ----------------
  logic [7:0]  tbl_hi   [8] = '{8'hF8, 8'h07, 8'h00, 8'hFF, 8'hA5, 8'h12, 8'h84, 8'hC3};
  logic [7:0]  tbl_lo   [8] = '{8'h1F, 8'hE0, 8'h00, 8'hFF, 8'h5A, 8'h34, 8'h21, 8'h96};
  logic [11:0] tbl_dout [8] = '{12'hF0F, 12'h0F0, 12'h000, 12'hFFF,
                                12'hAAD, 12'h14A, 12'h880, 12'hC7B};

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          exp_addr;
  int          checks   = 0;
  int          failures = 0;
  int          n_writes = 0;
  int          n0;
  logic        prev_fd  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected {addr, dout}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e[15:12]));
        check("wr_dout", 32'(dout), 32'(e[11:0]));
      end
    end
    if (frame_done === 1'b1 && prev_fd === 1'b1)
      check("frame_done_width", 32'd2, 32'd1);
    prev_fd = frame_done;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two bytes with href=1; pushes an expectation when capture should write.
  task automatic send_pixel(input int idx, input bit capturing);
    href = 1'b1;
    d    = tbl_hi[idx % 8];
    cyc();
    d    = tbl_lo[idx % 8];
    if (capturing && exp_addr < PXLS) begin
      exp_q.push_back({exp_addr[3:0], tbl_dout[idx % 8]});
      exp_addr++;
    end
    cyc();
  endtask

  task automatic send_line(input int n, input int start_idx, input bit capturing);
    for (int i = 0; i < n; i++) send_pixel(start_idx + i, capturing);
    href = 1'b0;
    cyc();
    cyc();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; cap_en = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00;
    exp_addr = 0;
    cyc(); cyc();
    check("rst_we",         32'(we),         32'd0);
    check("rst_addr",       32'(addr),       32'd0);
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_state",      32'(o_state),    32'(ST_IDLE));

    // Frame 1: exactly PXLS pixels, first pixel F8,1F.
    rst_n = 1'b1; cap_en = 1'b1; vsync = 1'b1;
    cyc();
    check("f1_state_wait", 32'(o_state), 32'(ST_WAIT));
    vsync = 1'b0;
    cyc();
    check("f1_state_active", 32'(o_state), 32'(ST_ACTIVE));
    exp_addr = 0;
    send_pixel(0, 1'b1);
    check("first_we",   32'(we),   32'd1);
    check("first_addr", 32'(addr), 32'd0);
    check("first_dout", 32'(dout), 32'hF0F);
    send_line(3, 1, 1'b1);
    send_line(4, 4, 1'b1);
    send_line(4, 8, 1'b1);
    check("f1_writes",    n_writes,        PXLS);
    check("f1_hold_addr", 32'(addr),       32'd11);
    check("f1_hold_dout", 32'(dout),       32'hFFF);
    check("f1_overflow",  32'(overflow),   32'd0);
    vsync = 1'b1;
    cyc();
    check("f1_frame_done", 32'(frame_done), 32'd1);
    cyc();
    check("f1_fd_low",  32'(frame_done),   32'd0);
    check("f1_state",   32'(o_state),      32'(ST_WAIT));
    check("f1_q_empty", exp_q.size(),      0);

    // Frame 2: PXLS+1 pixels -> last one dropped, overflow sticky.
    n0 = n_writes;
    vsync = 1'b0;
    cyc();
    exp_addr = 0;
    send_line(4, 0, 1'b1);
    send_line(4, 4, 1'b1);
    send_line(4, 8, 1'b1);
    send_pixel(12, 1'b1);
    check("ovf_no_we", 32'(we),       32'd0);
    check("ovf_set",   32'(overflow), 32'd1);
    href = 1'b0;
    cyc();
    check("f2_writes",    n_writes - n0, PXLS);
    check("f2_hold_addr", 32'(addr),     32'd11);
    vsync = 1'b1;
    cyc();
    check("f2_frame_done", 32'(frame_done), 32'd1);
    check("f2_ovf_hold",   32'(overflow),   32'd1);
    cyc(); cyc();
    check("f2_ovf_blank", 32'(overflow), 32'd1);
    vsync = 1'b0;
    cyc();
    check("f2_ovf_clear", 32'(overflow), 32'd0);
    check("f3_active",    32'(o_state),  32'(ST_ACTIVE));

    // Frame 3: 3-byte line, cap_en dropped mid-frame, short frame.
    n0 = n_writes;
    exp_addr = 0;
    send_pixel(1, 1'b1);
    d = tbl_hi[2];
    cyc();
    href = 1'b0;
    cyc();
    check("odd_line_writes", n_writes - n0, 1);
    cyc();
    send_line(2, 5, 1'b1);
    check("next_line_addr", 32'(addr), 32'd2);
    cap_en = 1'b0;
    send_line(1, 7, 1'b1);
    vsync = 1'b1;
    cyc();
    check("f3_frame_done", 32'(frame_done), 32'd1);
    check("f3_overflow",   32'(overflow),   32'd0);
    check("f3_state_idle", 32'(o_state),    32'(ST_IDLE));
    check("f3_writes",     n_writes - n0,   4);

    // Capture disabled: vsync toggles and href activity must not write.
    n0 = n_writes;
    cyc();
    vsync = 1'b0;
    cyc();
    send_line(2, 0, 1'b0);
    vsync = 1'b1;
    cyc(); cyc();
    vsync = 1'b0;
    send_line(2, 3, 1'b0);
    check("dis_writes", n_writes - n0,  0);
    check("dis_state",  32'(o_state),   32'(ST_IDLE));
    cap_en = 1'b1;
    cyc();
    check("en_low_vsync_idle", 32'(o_state), 32'(ST_IDLE));
    vsync = 1'b1;
    cyc();
    check("en_wait", 32'(o_state), 32'(ST_WAIT));
    send_line(1, 2, 1'b0);
    check("wait_href_ignored", n_writes - n0, 0);
    vsync = 1'b0;
    cyc();
    exp_addr = 0;
    send_pixel(4, 1'b1);
    check("en_first_addr", 32'(addr), 32'd0);
    check("en_first_dout", 32'(dout), 32'hAAD);
    send_line(3, 5, 1'b1);

    // Reset mid-frame with a half pixel pending.
    href = 1'b1;
    d    = tbl_hi[0];
    cyc();
    rst_n = 1'b0;
    href  = 1'b0;
    cyc();
    check("mid_rst_we",    32'(we),         32'd0);
    check("mid_rst_addr",  32'(addr),       32'd0);
    check("mid_rst_dout",  32'(dout),       32'd0);
    check("mid_rst_fd",    32'(frame_done), 32'd0);
    check("mid_rst_state", 32'(o_state),    32'(ST_IDLE));
    rst_n = 1'b1;
    cyc();
    check("post_rst_fd", 32'(frame_done), 32'd0);
    n0 = n_writes;
    send_line(1, 0, 1'b0);
    check("post_rst_no_write", n_writes - n0, 0);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
    exp_addr = 0;
    send_pixel(3, 1'b1);
    check("post_rst_addr", 32'(addr), 32'd0);
    check("post_rst_dout", 32'(dout), 32'hFFF);
    href = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
    check("post_rst_frame_done", 32'(frame_done), 32'd1);
    cyc(); cyc();
    check("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
